// File: rtl/mips_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
package mips_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned IMEM_AW    = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a program source and the loader.
interface imem_loader_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );

endinterface

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module imem_ram
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write the assembled word on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into instruction memory, then releases the CPU.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   nwords,
  imem_loader_if.slave  bus,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  loader_state_e state_q, state_d;
  logic [AW:0]   nwords_q, nwords_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW:0]   loaded_q, loaded_d;
  logic [31:0]   asm_q, asm_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          we;
  logic [31:0]   wdata;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic          byte_ready;
  logic          accept;
  logic          start_ok;
  logic          unused_pc;

  assign accept   = bus.byte_valid && (state_q == StLoad);
  assign start_ok = (nwords != '0) && (nwords <= DepthW);
  assign wdata    = {asm_q[23:0], bus.byte_data};
  assign raddr    = pc[AW+1:2];
  assign unused_pc = ^{pc[31:AW+2], pc[1:0]};

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      nwords_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= '0;
      asm_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      asm_q    <= asm_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state: start decoding, byte assembly and word commit.
  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    asm_d    = asm_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we       = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        if (start) begin
          if (start_ok) begin
            state_d  = StLoad;
            nwords_d = nwords;
            ptr_d    = '0;
            cnt_d    = '0;
            loaded_d = '0;
            asm_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // start is deliberately ignored while a load is in progress.
        if (accept) begin
          asm_d = wdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            we       = 1'b1;
            ptr_d    = ptr_q + AW'(1);
            loaded_d = loaded_q + (AW+1)'(1);
            if (loaded_q + (AW+1)'(1) == nwords_q) begin
              state_d = StRun;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_reset  = 1'b1;
    unique case (state_q)
      StLoad: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StRun:   cpu_reset = 1'b0;
      default: ;
    endcase
  end

  assign bus.byte_ready = byte_ready;
  assign done           = done_q;
  assign err            = err_q;

  // Words beyond the loaded count read as zero so stale contents never leak.
  assign instr = ({1'b0, raddr} < loaded_q) ? rdata : 32'h0000_0000;

  imem_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(ptr_q),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a word-level reference memory.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int DEPTH = IMEM_DEPTH;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [IMEM_AW:0] nwords;
  logic [31:0]     pc;
  logic [31:0]     instr;
  logic            cpu_reset;
  logic            busy;
  logic            done;
  logic            err;

  imem_loader_if bus ();

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .nwords   (nwords),
    .bus      (bus),
    .pc       (pc),
    .instr    (instr),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef enum int {EvDone = 0, EvErr = 1, EvInstr = 2} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] value;
    string       name;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        probe_req = 1'b0;
  int          hs_count = 0;
  logic [31:0] model_mem [DEPTH];
  int          model_loaded = 0;
  logic [31:0] stim_words [DEPTH];

  function automatic void check32(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endfunction

  // Word-level rule: index is pc/4 modulo depth; unloaded words read zero.
  function automatic logic [31:0] model_instr(input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) % DEPTH);
    if (idx < model_loaded) return model_mem[idx];
    return 32'h0;
  endfunction

  function automatic void pop_check(input ev_kind_e kind, input logic [31:0] act);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind=%0d actual=%h required=none", kind, act);
      return;
    end
    e = exp_q.pop_front();
    check32({e.name, "_kind"}, 32'(kind), 32'(e.kind));
    if (kind == EvInstr && e.kind == EvInstr) check32(e.name, act, e.value);
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.byte_valid && bus.byte_ready && reset) hs_count++;
      if (done === 1'b1) pop_check(EvDone, 32'h0);
      if (err === 1'b1) pop_check(EvErr, 32'h0);
      if (probe_req) pop_check(EvInstr, instr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input bit expect_err);
    if (expect_err) exp_q.push_back('{EvErr, 32'h0, "err_pulse"});
    start  = 1'b1;
    nwords = n[IMEM_AW:0];
    tick();
    start  = 1'b0;
    nwords = (IMEM_AW+1)'($urandom);
  endtask

  task automatic probe(input logic [31:0] a, input string name);
    pc = a;
    exp_q.push_back('{EvInstr, model_instr(a), name});
    probe_req = 1'b1;
    tick();
    probe_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      tick();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    while (!bus.byte_ready && t < 20) begin
      tick();
      t++;
    end
    if (!bus.byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
    tick();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
  endtask

  // mode 0: back-to-back, 1: one idle cycle per byte, 2: random gaps + ignored starts.
  task automatic load(input int n, input int mode, input int abort_after);
    int          h0;
    int          gap;
    logic [31:0] w32;
    do_start(n, 1'b0);
    check1("load_busy", busy, 1'b1);
    check1("load_byte_ready", bus.byte_ready, 1'b1);
    check1("load_cpu_reset", cpu_reset, 1'b1);
    model_loaded = 0;
    h0 = hs_count;
    for (int w = 0; w < n; w++) begin
      w32 = stim_words[w];
      for (int k = 0; k < 4; k++) begin
        if (abort_after == w * 4 + k) begin
          bus.byte_valid = 1'b0;
          reset = 1'b0;
          tick();
          reset = 1'b1;
          model_loaded = 0;
          check1("abort_cpu_reset", cpu_reset, 1'b1);
          check1("abort_byte_ready", bus.byte_ready, 1'b0);
          check1("abort_busy", busy, 1'b0);
          return;
        end
        if (mode == 2 && w == 0 && k == 2) begin
          do_start(0, 1'b0);
          do_start(n, 1'b0);
        end
        gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
        if (w == n - 1 && k == 3) begin
          exp_q.push_back('{EvDone, 32'h0, "done_pulse"});
          check1("pre_run_cpu_reset", cpu_reset, 1'b1);
        end
        send_byte(8'(w32 >> (24 - 8 * k)), gap);
      end
      model_mem[w] = w32;
      model_loaded = w + 1;
    end
    check1("run_cpu_reset", cpu_reset, 1'b0);
    check32("handshakes", 32'(hs_count - h0), 32'(n * 4));
  endtask

  initial begin
    int n;
    reset          = 1'b0;
    start          = 1'b1;
    nwords         = '0;
    pc             = 32'h0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (3) tick();
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    reset          = 1'b1;
    tick();

    check1("rst_byte_ready", bus.byte_ready, 1'b0);
    check1("rst_cpu_reset", cpu_reset, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    probe(32'h0, "rst_instr");

    // Rejected starts from IDLE.
    do_start(0, 1'b1);
    tick();
    check1("bad0_byte_ready", bus.byte_ready, 1'b0);
    check1("bad0_cpu_reset", cpu_reset, 1'b1);
    do_start(65, 1'b1);
    tick();
    check1("bad65_byte_ready", bus.byte_ready, 1'b0);
    check1("bad65_busy", busy, 1'b0);

    // Two-word load, back-to-back.
    stim_words[0] = 32'h2002_0005;
    stim_words[1] = 32'h2003_000C;
    load(2, 0, -1);
    tick();
    probe(32'h0000_0000, "fixed_pc0");
    probe(32'h0000_0004, "fixed_pc4");
    probe(32'h0000_0008, "fixed_pc8");
    probe(32'h0000_0101, "fixed_pc101");

    // Same load from RUN with byte_valid toggling.
    load(2, 1, -1);
    tick();
    probe(32'h0000_0000, "toggle_pc0");
    probe(32'h0000_0004, "toggle_pc4");

    // Rejected starts from RUN keep the CPU running.
    do_start(65, 1'b1);
    tick();
    check1("bad_run_cpu_reset", cpu_reset, 1'b0);
    do_start(0, 1'b1);
    tick();
    check1("bad_run_byte_ready", bus.byte_ready, 1'b0);

    // Reset after six bytes, then a full reload with ignored mid-load starts.
    load(2, 0, 6);
    tick();
    probe(32'h0000_0000, "abort_pc0");
    load(2, 2, -1);
    tick();
    probe(32'h0000_0000, "reload_pc0");
    probe(32'h0000_0004, "reload_pc4");

    // Single-word load from RUN.
    stim_words[0] = 32'hAC02_0004;
    load(1, 0, -1);
    tick();
    probe(32'h0000_0000, "one_pc0");
    probe(32'h0000_0004, "one_pc4");

    // Randomized loads, including a full-depth load.
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
      for (int i = 0; i < DEPTH; i++) stim_words[i] = $urandom;
      load(n, 2, -1);
      tick();
      for (int p = 0; p < 8; p++) probe($urandom, "rand_instr");
      probe(32'((n - 1) * 4), "rand_last");
      probe(32'(n * 4), "rand_past");
    end

    repeat (3) tick();
    check32("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
